// File: rtl/narrow_pulse_pkg.sv
// Shared types and helpers for the narrow-and-sync pulse receiver.
package narrow_pulse_pkg;

  typedef enum logic [1:0] {IDLE, QUAL, HOLD} npulse_state_t;

  // Width of the PHASE parameter: eight ASCII characters.
  localparam int PHASE_W = 64;

  // Level the event line rests at when no event is present.
  function automatic logic lvl_inactive(input logic [PHASE_W-1:0] phase);
    return (phase == "NEGATIVE");
  endfunction

endpackage

// File: rtl/cross_clk_sync_bit.sv
// Single-bit synchronizer: a chain of LAT flops, or a wire when LAT is 0.
module cross_clk_sync_bit #(
  parameter int   LAT     = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (LAT == 0) begin : g_bypass
    // Clock and reset have no job in the bypass case.
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ rst_n;
    assign q = d;
  end else begin : g_chain
    logic [LAT-1:0] sync_q;

    // Shift the line through the chain; reset loads the idle level so no false edge appears.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {LAT{RST_VAL}};
      end else begin
        sync_q[0] <= d;
        for (int i = 1; i < LAT; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign q = sync_q[LAT-1];
  end

endmodule

// File: rtl/narrow_and_sync_pulse.sv
// Receive side of a broadened event link: synchronize, qualify the run
// length, and emit one single-cycle pulse per event (plus a glitch flag).
module narrow_and_sync_pulse
  import narrow_pulse_pkg::*;
#(
  parameter logic [PHASE_W-1:0] PHASE   = "POSITIVE",
  parameter int                 LEN     = 4,
  parameter int                 MIN_LEN = 2,
  parameter int                 LAT     = 2
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic glitch,
  output logic busy
);

  localparam logic INACT = lvl_inactive(PHASE);
  localparam int   RC_W  = (LEN < 1) ? 1 : $clog2(LEN + 1);

  localparam logic [RC_W-1:0] ONE     = RC_W'(1);
  localparam logic [RC_W-1:0] MIN_RC  = RC_W'(MIN_LEN);
  localparam logic [RC_W-1:0] LAST_PH = RC_W'(LEN - 1);

  if (LEN < 1 || MIN_LEN < 1 || MIN_LEN > LEN) begin : g_bad_params
    $error("narrow_and_sync_pulse: illegal LEN=%0d MIN_LEN=%0d", LEN, MIN_LEN);
  end

  logic          s_raw;
  logic          s;
  npulse_state_t state_q;
  logic [RC_W-1:0] rc_q;
  logic [RC_W-1:0] phase_q;
  logic          q_q;
  logic          glitch_q;
  logic          busy_q;

  cross_clk_sync_bit #(
    .LAT     (LAT),
    .RST_VAL (INACT)
  ) u_sync (
    .clock (clock),
    .rst_n (rst_n),
    .d     (d),
    .q     (s_raw)
  );

  // Active level mapped to 1 regardless of PHASE.
  assign s = s_raw ^ INACT;

  // Run qualification FSM; q/glitch/busy are registered alongside the state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rc_q     <= '0;
      phase_q  <= '0;
      q_q      <= 1'b0;
      glitch_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      q_q      <= 1'b0;
      glitch_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s) begin
            rc_q    <= ONE;
            phase_q <= '0;
            busy_q  <= 1'b1;
            if (MIN_LEN == 1) begin
              state_q <= HOLD;
              q_q     <= 1'b1;
            end else begin
              state_q <= QUAL;
            end
          end else begin
            rc_q   <= '0;
            busy_q <= 1'b0;
          end
        end
        QUAL: begin
          if (s) begin
            rc_q <= rc_q + ONE;
            if (rc_q + ONE == MIN_RC) begin
              state_q <= HOLD;
              phase_q <= '0;
              q_q     <= 1'b1;
            end
          end else begin
            // Run ended before it qualified.
            state_q  <= IDLE;
            rc_q     <= '0;
            glitch_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        HOLD: begin
          if (s) begin
            // Every further LEN cycles of the same run is another merged event.
            if (phase_q == LAST_PH) begin
              phase_q <= '0;
              q_q     <= 1'b1;
            end else begin
              phase_q <= phase_q + ONE;
            end
          end else begin
            state_q <= IDLE;
            rc_q    <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rc_q    <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q      = q_q;
  assign glitch = glitch_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_narrow_and_sync_pulse.sv
// Bench for narrow_and_sync_pulse: two configurations share one stimulus
// line; a run-length reference model predicts q/glitch/busy every cycle.
module tb_narrow_and_sync_pulse;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic d     = 1'b0;
  logic q_a, g_a, b_a;
  logic q_b, g_b, b_b;

  always #5 clock = ~clock;

  // Default configuration: POSITIVE, LEN=4, MIN_LEN=2, LAT=2.
  narrow_and_sync_pulse dut_a (
    .clock  (clock),
    .rst_n  (rst_n),
    .d      (d),
    .q      (q_a),
    .glitch (g_a),
    .busy   (b_a)
  );

  // Low-active, single-cycle qualification, no synchronizer.
  narrow_and_sync_pulse #(
    .PHASE   ("NEGATIVE"),
    .LEN     (4),
    .MIN_LEN (1),
    .LAT     (0)
  ) dut_b (
    .clock  (clock),
    .rst_n  (rst_n),
    .d      (d),
    .q      (q_b),
    .glitch (g_b),
    .busy   (b_b)
  );

  typedef struct packed {
    logic [2:0] a;   // {q, glitch, busy}
    logic [2:0] b;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   qcnt[2] = '{0, 0};
  int   gcnt[2] = '{0, 0};

  // Reference model state: raw d history per step, last reset step, run length.
  logic dhist [0:8191];
  int   n = 0;
  int   last_rst[2] = '{0, 0};
  int   rc[2]       = '{0, 0};

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction
  function automatic int min_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic int len_of(input int i);
    return 4;
  endfunction
  function automatic logic neg_of(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  // s(n) = normalized d(n-LAT), idle until LAT samples after reset; q fires at
  // run lengths MIN_LEN + k*LEN, glitch when a run ends short of MIN_LEN.
  task automatic model_step(input int i, input logic rv, output logic [2:0] e);
    logic s;
    int   prev;
    if (!rv) begin
      last_rst[i] = n;
      rc[i]       = 0;
      e           = 3'b000;
    end else begin
      if (n - lat_of(i) > last_rst[i]) s = dhist[n - lat_of(i)] ^ neg_of(i);
      else s = 1'b0;
      prev  = rc[i];
      rc[i] = s ? rc[i] + 1 : 0;
      e[2]  = s && (rc[i] >= min_of(i)) && (((rc[i] - min_of(i)) % len_of(i)) == 0);
      e[1]  = !s && (prev > 0) && (prev < min_of(i));
      e[0]  = (rc[i] > 0);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Drive one clock's worth of input and push the expected response after that edge.
  task automatic step(input logic dv, input logic rv);
    logic [2:0] ea, eb;
    logic       was;
    @(posedge clock);
    #3;
    was   = rst_n;
    d     = dv;
    rst_n = rv;
    if (n < 8192) dhist[n] = dv;
    model_step(0, rv, ea);
    model_step(1, rv, eb);
    n++;
    expq.push_back('{a: ea, b: eb});
    if (was && !rv) begin
      #1;
      check_int("rst_async_clear", int'({q_a, g_a, b_a, q_b, g_b, b_b}), 0);
    end
  endtask

  task automatic idle_a(input int cyc);
    repeat (cyc) step(1'b0, 1'b1);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    int   k;
    k = 0;
    forever begin
      @(posedge clock);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        total++;
        if ({q_a, g_a, b_a} !== e.a) begin
          bad++;
          $display("FAIL dut_a_out step=%0d got q,glitch,busy=%b want=%b", k, {q_a, g_a, b_a}, e.a);
        end
        total++;
        if ({q_b, g_b, b_b} !== e.b) begin
          bad++;
          $display("FAIL dut_b_out step=%0d got q,glitch,busy=%b want=%b", k, {q_b, g_b, b_b}, e.b);
        end
        if (q_a === 1'b1) qcnt[0]++;
        if (g_a === 1'b1) gcnt[0]++;
        if (q_b === 1'b1) qcnt[1]++;
        if (g_b === 1'b1) gcnt[1]++;
        k++;
      end
    end
  end

  initial begin
    int   q0, g0;
    logic lvl;
    int   len;
    repeat (3) step(1'b0, 1'b0);
    check_int("reset_outputs", int'({q_a, g_a, b_a, q_b, g_b, b_b}), 0);
    idle_a(8);

    // Four-cycle run: a single pulse.
    q0 = qcnt[0]; g0 = gcnt[0];
    repeat (4) step(1'b1, 1'b1);
    idle_a(8);
    check_int("run4_q", qcnt[0] - q0, 1);
    check_int("run4_glitch", gcnt[0] - g0, 0);

    // Eight-cycle run: two merged events.
    q0 = qcnt[0]; g0 = gcnt[0];
    repeat (8) step(1'b1, 1'b1);
    idle_a(8);
    check_int("run8_q", qcnt[0] - q0, 2);
    check_int("run8_glitch", gcnt[0] - g0, 0);

    // One-cycle run: glitch only.
    q0 = qcnt[0]; g0 = gcnt[0];
    step(1'b1, 1'b1);
    idle_a(8);
    check_int("run1_q", qcnt[0] - q0, 0);
    check_int("run1_glitch", gcnt[0] - g0, 1);

    // Two MIN_LEN runs split by one idle cycle: both qualify.
    q0 = qcnt[0]; g0 = gcnt[0];
    repeat (2) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1);
    idle_a(8);
    check_int("split_q", qcnt[0] - q0, 2);
    check_int("split_glitch", gcnt[0] - g0, 0);

    // Reset pulse on the fourth active cycle, then a clean run.
    q0 = qcnt[0]; g0 = gcnt[0];
    repeat (3) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    idle_a(6);
    check_int("rst_mid_q", qcnt[0] - q0, 0);
    repeat (4) step(1'b1, 1'b1);
    idle_a(8);
    check_int("after_rst_q", qcnt[0] - q0, 1);
    check_int("after_rst_glitch", gcnt[0] - g0, 0);

    // Low-active instance: reset with d at its idle level, then a 3-cycle low run.
    repeat (2) step(1'b1, 1'b0);
    q0 = qcnt[1]; g0 = gcnt[1];
    repeat (5) step(1'b1, 1'b1);
    check_int("neg_idle_q", qcnt[1] - q0, 0);
    check_int("neg_idle_glitch", gcnt[1] - g0, 0);
    repeat (3) step(1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b1);
    check_int("neg_run3_q", qcnt[1] - q0, 1);
    check_int("neg_run3_glitch", gcnt[1] - g0, 0);

    // Random runs of both levels with occasional resets.
    repeat (300) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 10));
      repeat (len) step(lvl, 1'b1);
      if ($urandom_range(0, 39) == 0) step(lvl, 1'b0);
    end
    repeat (3) step(1'b0, 1'b1);

    for (int w = 0; w < 10 && expq.size() > 0; w++) @(posedge clock);
    #2;
    check_int("drain_timeout", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
